sccomp: RTL and testbench

// - Single-cycle MIPS-subset computer: PC, register file, ALU, control, instruction ROM and data RAM.
// - Executes one instruction per clock from a word ROM preloaded by simulation.
// - Exposes any GPR on a debug read port for checking.
// - Top of the single-cycle CPU design; no external memory bus.

---
 rtl/sccomp.sv | 143 ++++++++++++++
 tb/tb_sccomp.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sccomp.sv
// Single-cycle MIPS-subset computer. Fetch, decode, execute, memory access and
// writeback all settle combinationally and then commit on one rising edge.
`timescale 1ns/1ps

module sccomp_im #(
   parameter int IM_DEPTH = 256,
   parameter int AW       = $clog2(IM_DEPTH)
) (
   input  logic [AW-1:0] i_addr,
   output logic [31:0]   o_dout
);
   // The simulation environment preloads this array. The hardware has no write path into it.
   logic [31:0] ROM [0:IM_DEPTH-1];

   assign o_dout = ROM[i_addr];
endmodule

module sccomp #(
   parameter int IM_DEPTH = 256,
   parameter int DM_DEPTH = 128
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [4:0]  reg_sel,
   output logic [31:0] reg_data
);
   localparam int IAW = $clog2(IM_DEPTH);
   localparam int DAW = $clog2(DM_DEPTH);

   logic [31:0]    PC;
   logic [31:0]    instr;
   logic [31:0]    r_gpr [0:31];
   logic [31:0]    r_dm  [0:DM_DEPTH-1];

   logic [5:0]     w_op, w_fn;
   logic [4:0]     w_rs, w_rt, w_rd, w_sh, w_wa;
   logic [31:0]    w_a, w_b, w_simm, w_zimm, w_sum, w_pc4, w_br, w_jt;
   logic [31:0]    w_ld, w_wd, w_npc;
   logic [DAW-1:0] w_dmi;
   logic           w_we, w_dm_we;

   sccomp_im #(.IM_DEPTH(IM_DEPTH)) U_IM (
      .i_addr (PC[IAW+1:2]),
      .o_dout (instr)
   );

   assign w_op   = instr[31:26];
   assign w_rs   = instr[25:21];
   assign w_rt   = instr[20:16];
   assign w_rd   = instr[15:11];
   assign w_sh   = instr[10:6];
   assign w_fn   = instr[5:0];

   // Reset clears r_gpr[0], and nothing ever writes it, so reads of $0 return 0.
   assign w_a    = r_gpr[w_rs];
   assign w_b    = r_gpr[w_rt];
   assign w_simm = {{16{instr[15]}}, instr[15:0]};
   assign w_zimm = {16'h0000, instr[15:0]};
   assign w_sum  = w_a + w_simm;
   assign w_pc4  = PC + 32'd4;
   assign w_br   = w_pc4 + {w_simm[29:0], 2'b00};
   assign w_jt   = {w_pc4[31:28], instr[25:0], 2'b00};
   assign w_dmi  = w_sum[DAW+1:2];
   assign w_ld   = r_dm[w_dmi];

   assign reg_data = r_gpr[reg_sel];

   always_comb begin
      w_we    = 1'b0;
      w_wa    = w_rt;
      w_wd    = '0;
      w_dm_we = 1'b0;
      w_npc   = w_pc4;
      case (w_op)
         6'h00: begin
            w_we = 1'b1;
            w_wa = w_rd;
            case (w_fn)
               6'h20, 6'h21: w_wd = w_a + w_b;
               6'h22, 6'h23: w_wd = w_a - w_b;
               6'h24:        w_wd = w_a & w_b;
               6'h25:        w_wd = w_a | w_b;
               6'h26:        w_wd = w_a ^ w_b;
               6'h27:        w_wd = ~(w_a | w_b);
               6'h2A:        w_wd = {31'd0, $signed(w_a) < $signed(w_b)};
               6'h2B:        w_wd = {31'd0, w_a < w_b};
               6'h00:        w_wd = w_b << w_sh;
               6'h02:        w_wd = w_b >> w_sh;
               6'h03:        w_wd = 32'($signed(w_b) >>> w_sh);
               6'h04:        w_wd = w_b << w_a[4:0];
               6'h06:        w_wd = w_b >> w_a[4:0];
               6'h08: begin
                  w_we  = 1'b0;
                  w_npc = w_a;
               end
               6'h09: begin
                  w_wd  = w_pc4;
                  w_npc = w_a;
               end
               default:      w_we = 1'b0;
            endcase
         end
         6'h08: begin w_we = 1'b1; w_wd = w_sum; end
         6'h0C: begin w_we = 1'b1; w_wd = w_a & w_zimm; end
         6'h0D: begin w_we = 1'b1; w_wd = w_a | w_zimm; end
         6'h0A: begin w_we = 1'b1; w_wd = {31'd0, $signed(w_a) < $signed(w_simm)}; end
         6'h0F: begin w_we = 1'b1; w_wd = {instr[15:0], 16'h0000}; end
         6'h23: begin w_we = 1'b1; w_wd = w_ld; end
         6'h2B: w_dm_we = 1'b1;
         6'h04: if (w_a == w_b) w_npc = w_br;
         6'h05: if (w_a != w_b) w_npc = w_br;
         6'h02: w_npc = w_jt;
         6'h03: begin
            w_we  = 1'b1;
            w_wa  = 5'd31;
            w_wd  = w_pc4;
            w_npc = w_jt;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) PC <= '0;
      else       PC <= w_npc;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
      end else if (w_we && (w_wa != 5'd0)) begin
         r_gpr[w_wa] <= w_wd;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DM_DEPTH; i++) r_dm[i] <= '0;
      end else if (w_dm_we) begin
         r_dm[w_dmi] <= w_b;
      end
   end
endmodule

// File: tb/tb_sccomp.sv
// Bench for sccomp. A directed program exercises each feature, then random programs
// are run in lockstep against an instruction-level model of the ISA.
`timescale 1ns/1ps

module tb_sccomp;
   logic        gclk = 1'b1;
   logic        grst_n = 1'b1;
   logic [4:0]  reg_sel = '0;
   logic [31:0] reg_data;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] rom   [0:255];
   logic [31:0] m_gpr [0:31];
   logic [31:0] m_ram [0:127];
   logic [31:0] m_pc;
   logic [5:0]  fns   [0:14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06};

   sccomp dut (
      .clk      (gclk),
      .rstn     (grst_n),
      .reg_sel  (reg_sel),
      .reg_data (reg_data)
   );

   always #5 gclk = ~gclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rt_i(input int rs, rt, rd, sh, fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction

   function automatic logic [31:0] it_i(input int op, rs, rt, input logic [15:0] imm);
      return {6'(op), 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] jt_i(input int op, input logic [25:0] tgt);
      return {6'(op), tgt};
   endfunction

   // Architectural model: one call executes one instruction.
   task automatic model_step();
      logic [31:0] ins, a, b, simm, zimm, pc4, npc, wv, ea;
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd, sh, wa;
      bit          we;
      ins  = rom[m_pc[9:2]];
      op   = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
      rd   = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
      a    = m_gpr[rs];  b  = m_gpr[rt];
      simm = {{16{ins[15]}}, ins[15:0]};
      zimm = {16'h0, ins[15:0]};
      pc4  = m_pc + 32'd4;
      npc  = pc4; we = 0; wa = rt; wv = 0;
      ea   = a + simm;
      if (op == 6'h00) begin
         we = 1; wa = rd;
         case (fn)
            6'h20, 6'h21: wv = a + b;
            6'h22, 6'h23: wv = a - b;
            6'h24: wv = a & b;
            6'h25: wv = a | b;
            6'h26: wv = a ^ b;
            6'h27: wv = ~(a | b);
            6'h2A: wv = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6'h2B: wv = (a < b) ? 32'd1 : 32'd0;
            6'h00: wv = b << sh;
            6'h02: wv = b >> sh;
            6'h03: wv = 32'(int'(b) >>> sh);
            6'h04: wv = b << a[4:0];
            6'h06: wv = b >> a[4:0];
            6'h08: begin we = 0; npc = a; end
            6'h09: begin wv = pc4; npc = a; end
            default: we = 0;
         endcase
      end else begin
         case (op)
            6'h08: begin we = 1; wv = ea; end
            6'h0C: begin we = 1; wv = a & zimm; end
            6'h0D: begin we = 1; wv = a | zimm; end
            6'h0A: begin we = 1; wv = (int'(a) < int'(simm)) ? 32'd1 : 32'd0; end
            6'h0F: begin we = 1; wv = {ins[15:0], 16'h0}; end
            6'h23: begin we = 1; wv = m_ram[ea[8:2]]; end
            6'h2B: m_ram[ea[8:2]] = b;
            6'h04: if (a == b) npc = pc4 + (simm << 2);
            6'h05: if (a != b) npc = pc4 + (simm << 2);
            6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
            6'h03: begin we = 1; wa = 5'd31; wv = pc4; npc = {pc4[31:28], ins[25:0], 2'b00}; end
            default: ;
         endcase
      end
      if (we && wa != 0) m_gpr[wa] = wv;
      m_pc = npc;
   endtask

   task automatic model_reset();
      m_pc = '0;
      for (int i = 0; i < 32; i++)  m_gpr[i] = '0;
      for (int i = 0; i < 128; i++) m_ram[i] = '0;
   endtask

   task automatic load_rom();
      for (int i = 0; i < 256; i++) dut.U_IM.ROM[i] = rom[i];
   endtask

   task automatic tick();
      @(posedge gclk);
      if (grst_n) model_step();
      #2;
      chk("pc", dut.PC, m_pc);
      reg_sel = 5'($urandom_range(0, 31));
      #0.1;
      chk("gpr", reg_data, m_gpr[reg_sel]);
   endtask

   task automatic chk_reg(input string tag, input int n, input logic [31:0] exp);
      reg_sel = 5'(n);
      #0.1;
      chk(tag, reg_data, exp);
   endtask

   function automatic logic [4:0] rr();
      return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
   endfunction

   function automatic logic [31:0] rnd_instr();
      int k;
      k = $urandom_range(0, 29);
      if (k < 15)  return rt_i(rr(), rr(), rr(), $urandom_range(0, 31), fns[k]);
      case (k)
         15: return rt_i(rr(), 0, 0, 0, 6'h08);
         16: return rt_i(rr(), 0, rr(), 0, 6'h09);
         17: return it_i(6'h08, rr(), rr(), 16'($urandom));
         18: return it_i(6'h0C, rr(), rr(), 16'($urandom));
         19: return it_i(6'h0D, rr(), rr(), 16'($urandom));
         20: return it_i(6'h0A, rr(), rr(), 16'($urandom));
         21: return it_i(6'h0F, 0, rr(), 16'($urandom));
         22, 23: return it_i(6'h23, ($urandom_range(0, 1) != 0) ? 5'd0 : rr(), rr(), 16'($urandom_range(0, 63)));
         24, 25: return it_i(6'h2B, ($urandom_range(0, 1) != 0) ? 5'd0 : rr(), rr(), 16'($urandom_range(0, 63)));
         26: return it_i(6'h04, rr(), rr(), 16'(int'($urandom_range(0, 8)) - 3));
         27: return it_i(6'h05, rr(), rr(), 16'(int'($urandom_range(0, 8)) - 3));
         28: return jt_i($urandom_range(2, 3), 26'($urandom_range(0, 255)));
         default: return ($urandom_range(0, 1) != 0) ? it_i(6'h3F, rr(), rr(), 16'($urandom))
                                                   : rt_i(rr(), rr(), rr(), 0, 6'h01);
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = '0;
      rom[8'h00] = it_i(6'h0F, 0, 1, 16'h1234);
      rom[8'h01] = it_i(6'h0D, 1, 1, 16'h5678);
      rom[8'h02] = it_i(6'h08, 0, 2, 16'hFFFF);
      rom[8'h03] = jt_i(3, 26'h20);
      rom[8'h04] = rt_i(1, 2, 3, 0, 6'h20);
      rom[8'h05] = rt_i(2, 1, 4, 0, 6'h2A);
      rom[8'h06] = rt_i(2, 1, 6, 0, 6'h2B);
      rom[8'h07] = it_i(6'h2B, 0, 1, 16'h0008);
      rom[8'h08] = it_i(6'h23, 0, 5, 16'h0008);
      rom[8'h09] = it_i(6'h08, 0, 0, 16'h0005);
      rom[8'h0A] = it_i(6'h04, 0, 0, 16'h0001);
      rom[8'h0B] = it_i(6'h08, 0, 7, 16'h0077);
      rom[8'h0C] = it_i(6'h05, 0, 0, 16'h0001);
      rom[8'h0D] = it_i(6'h08, 0, 9, 16'h0003);
      rom[8'h0E] = it_i(6'h08, 8, 8, 16'h0001);
      rom[8'h0F] = it_i(6'h05, 8, 9, 16'hFFFE);
      rom[8'h10] = jt_i(2, 26'h10);
      rom[8'h20] = it_i(6'h08, 0, 10, 16'h0055);
      rom[8'h21] = rt_i(31, 0, 0, 0, 6'h08);
      load_rom();

      #5 grst_n = 1'b0;
      model_reset();
      #6;
      chk("rst_pc", dut.PC, 32'h0);
      for (int i = 0; i < 32; i++) chk_reg("rst_gpr", i, 32'h0);
      #(25 - $realtime) grst_n = 1'b1;
      tick();
      chk("pc_first", dut.PC, 32'h4);

      repeat (3) tick();
      chk("jal_pc", dut.PC, 32'h80);
      chk_reg("jal_ra", 31, 32'h10);
      repeat (2) tick();
      chk("jr_pc", dut.PC, 32'h10);
      repeat (7) tick();
      chk("beq_skip", dut.PC, 32'h30);
      tick();
      chk("bne_fall", dut.PC, 32'h34);
      repeat (9) tick();
      chk("halt_pc", dut.PC, 32'h40);
      chk_reg("lui_ori", 1, 32'h12345678);
      chk_reg("addi_m1", 2, 32'hFFFFFFFF);
      chk_reg("add",     3, 32'h12345677);
      chk_reg("slt",     4, 32'h1);
      chk_reg("sltu",    6, 32'h0);
      chk_reg("lw",      5, 32'h12345678);
      chk_reg("r0",      0, 32'h0);
      chk_reg("skipped", 7, 32'h0);
      chk_reg("loop",    8, 32'h3);
      chk_reg("sub_ret", 10, 32'h55);

      #2 grst_n = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_pc", dut.PC, 32'h0);
      chk_reg("mid_rst_gpr", 1, 32'h0);
      @(posedge gclk); #2;
      chk("rst_hold_pc", dut.PC, 32'h0);
      @(negedge gclk) grst_n = 1'b1;
      tick();
      chk("restart_pc", dut.PC, 32'h4);
      repeat (30) tick();

      for (int p = 0; p < 3; p++) begin
         @(negedge gclk) grst_n = 1'b0;
         model_reset();
         for (int i = 0; i < 256; i++) rom[i] = rnd_instr();
         load_rom();
         #1 chk("rnd_rst_pc", dut.PC, 32'h0);
         @(negedge gclk) grst_n = 1'b1;
         for (int k = 0; k < 600; k++) begin
            tick();
            if (p == 1 && k == 300) begin
               #2 grst_n = 1'b0;
               model_reset();
               #1 chk("rnd_mid_rst_pc", dut.PC, 32'h0);
               @(negedge gclk) grst_n = 1'b1;
            end
         end
         for (int i = 0; i < 32; i++)  chk_reg("rnd_gpr", i, m_gpr[i]);
         for (int i = 0; i < 128; i++) chk("rnd_ram", dut.r_dm[i], m_ram[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
